sdr_port_responder: RTL
=======================

// Module: sdr_port_responder
// PURPOSE
// - Target (responder) end of the single-word SDRAM port handshake (sdr_*_addr/din/wr_sel/req -> dout/rdy)
//   that the CPU bus bridge issues on CLK_96M.
// - Backs the port with an on-chip word array so the CPU path runs without the SDRAM controller
//   (BRAM-backed builds, simulation).
// - Queues up to 2 requests and answers each with a single-cycle rdy pulse after a fixed latency.
// PARAMETERS
// - ADDR_W          16     word-address bits used; array depth 2**ADDR_W x 16
// - LATENCY         4      cycles from service start to rdy; legal 2..15
// - REFRESH_PERIOD  768    cycles between refresh stalls (SDR_RESP_REFRESH_EN only)
// - REFRESH_CYCLES  8      length of one refresh stall in cycles (SDR_RESP_REFRESH_EN only)
// - INIT_FILE       ""     $readmemh image for the array; empty = no init
// PORTS
// - CLK_96M     in   1    sole clock; every register updates on its rising edge
// - reset       in   1    synchronous, active-high
// - sdr_addr    in   24   [24:1] word address; only [ADDR_W:1] decoded, upper bits ignored
// - sdr_din     in   16   write data, sampled with req
// - sdr_wr_sel  in   2    byte enables [1]=hi [0]=lo; 2'b00 = read; sampled with req
// - sdr_req     in   1    one-cycle request strobe
// - sdr_dout    out  16   response word, valid in the cycle sdr_rdy=1, held until the next rdy
// - sdr_rdy     out  1    one-cycle completion pulse, one per accepted request
// - busy        out  1    1 while the queue is non-empty or a refresh stall is active
// - overflow    out  1    sticky: set when a req arrives with the queue full; cleared only by reset
// BEHAVIOUR
// - Reset values: sdr_dout=0, sdr_rdy=0, busy=0, overflow=0; queue emptied; FSM=IDLE; latency and refresh
//   counters=0. Array contents are retained.
// - Queue: 2-entry FIFO of {addr, din, wr_sel}. A req is enqueued in the cycle it is high.
//   - Req with FIFO full (2 entries): dropped, overflow<=1, no rdy is ever produced for it.
//   - Req in the same cycle as a rdy retirement: the retiring entry frees its slot first, so the req is accepted.
// - FSM states: IDLE, WAIT, (REFRESH when the macro is defined).
//   - IDLE -> WAIT when the FIFO is non-empty; latency counter loads 1.
//   - WAIT: counter increments each cycle. At counter==LATENCY: commit, rdy=1 for that cycle, pop the head,
//     go to IDLE. IDLE re-enters WAIT on the next cycle if the FIFO is still non-empty.
//   - Latency: req at cycle T into an empty, idle block -> rdy at T+LATENCY (T+1 = first WAIT cycle).
//   - Back-to-back: a queued request's rdy comes LATENCY+1 cycles after the previous rdy.
// - Commit, in the rdy cycle:
//   - wr_sel==00: sdr_dout <= array[addr].
//   - otherwise: write the selected bytes of din into array[addr]; sdr_dout <= merged new word
//     (unselected bytes keep the old data).
//   - Ordering: a read queued behind a write to the same address returns the written data.
// - busy = FIFO non-empty | FSM==REFRESH.
// - Reset asserted mid-operation: pending and in-flight requests are discarded, no rdy is issued, and no array
//   write occurs unless the commit cycle coincides with the reset cycle (reset wins; the write is suppressed).
// - Array is inferred as single-port BRAM (one read-or-write per cycle); the commit is the only access.
// CONFIGURATION
// - Macro SDR_RESP_REFRESH_EN.
// - Defined:
//   - A free-running counter wraps every REFRESH_PERIOD cycles and raises refresh_pending.
//   - In IDLE with refresh_pending: enter REFRESH for exactly REFRESH_CYCLES cycles, clear pending, then IDLE.
//   - refresh_pending takes priority over a non-empty FIFO when in IDLE.
//   - A WAIT in progress is never interrupted; the refresh runs after its rdy.
//   - Reqs arriving during REFRESH are queued; their LATENCY count starts on leaving REFRESH.
// - Undefined: no REFRESH state and no refresh counter; latency is always exactly as in BEHAVIOUR.
// TESTING
// 1. Reset, then read 0x0010 with the array preloaded to 0xBEEF -> rdy exactly LATENCY cycles after req,
//    dout=0xBEEF, busy high over [req+1 .. rdy].
// 2. Write 0x1234 to 0x0020 with wr_sel=10 over old 0xAAAA -> dout=0x12AA at rdy;
//    subsequent read of 0x0020 returns 0x12AA.
// 3. Three reqs in consecutive cycles (write 0x5555 @0x30 wr_sel=11, read @0x30, read @0x31)
//    -> third dropped, overflow=1; exactly two rdy pulses, LATENCY+1 apart, second dout=0x5555.
// 4. Req issued in the same cycle as a rdy with 1 entry queued -> accepted, overflow stays 0.
// 5. Reset asserted 2 cycles after a write req to 0x40 (LATENCY=4) -> no rdy,
//    array[0x40] unchanged, all outputs 0 on the next cycle.
// 6. SDR_RESP_REFRESH_EN, REFRESH_PERIOD=32, REFRESH_CYCLES=8: req issued in the first REFRESH cycle
//    -> rdy at (refresh end)+LATENCY; req during WAIT at wrap -> rdy unaffected, refresh follows.

Source files
------------

// File: rtl/sdr_port_responder.sv
// sdr_port_responder: on-chip word array answering the single-word SDRAM port.
// Optional periodic refresh stalls are built in when SDR_RESP_REFRESH_EN is defined.
module sdr_port_responder #(
  parameter int ADDR_W         = 16,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 768,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic        CLK_96M,
  input  logic        reset,
  input  logic [24:1] sdr_addr,
  input  logic [15:0] sdr_din,
  input  logic [1:0]  sdr_wr_sel,
  input  logic        sdr_req,
  output logic [15:0] sdr_dout,
  output logic        sdr_rdy,
  output logic        busy,
  output logic        overflow
);

`ifdef SDR_RESP_REFRESH_EN
  localparam int CW = (REFRESH_CYCLES > 15) ? $clog2(REFRESH_CYCLES + 1) : 4;
  localparam int RW = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, REFRESH} state_e;
`else
  localparam int CW = 4;
  typedef enum logic [1:0] {IDLE, WAIT} state_e;
`endif
  localparam int EW = ADDR_W + 18;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        fill_q;
  logic [1:0]        fill_d;
  logic [EW-1:0]     fifo_q [2];
  logic [15:0]       mem_q [2**ADDR_W];
  logic [EW-1:0]     new_e;
  logic [ADDR_W-1:0] h_addr;
  logic [15:0]       h_din;
  logic [1:0]        h_sel;
  logic              commit;
  logic              pop;
  logic              enq;
  logic              unused_ok;

  assign {h_addr, h_din, h_sel} = fifo_q[0];
  assign new_e  = {sdr_addr[ADDR_W:1], sdr_din, sdr_wr_sel};
  // Commit one cycle before the rdy cycle; the head is popped at the end of rdy.
  assign commit = (state_q == WAIT) && (cnt_q == CW'(LATENCY - 1));
  assign pop    = (state_q == WAIT) && (cnt_q == CW'(LATENCY));
  assign enq    = sdr_req && ((fill_q != 2'd2) || pop);
  assign fill_d = fill_q + {1'b0, enq} - {1'b0, pop};

`ifdef SDR_RESP_REFRESH_EN
  logic [RW-1:0] rctr_q;
  logic          rpend_q;
  assign busy = (fill_q != 2'd0) || (state_q == REFRESH);
  assign unused_ok = ^sdr_addr[24:ADDR_W+1];
`else
  assign busy = (fill_q != 2'd0);
  assign unused_ok = ^{sdr_addr[24:ADDR_W+1], REFRESH_PERIOD, REFRESH_CYCLES};
`endif

  always_ff @(posedge CLK_96M) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fill_q   <= '0;
      sdr_rdy  <= 1'b0;
      overflow <= 1'b0;
`ifdef SDR_RESP_REFRESH_EN
      rctr_q   <= '0;
      rpend_q  <= 1'b0;
`endif
    end else begin
      fill_q  <= fill_d;
      sdr_rdy <= commit;
      if (sdr_req && !enq) overflow <= 1'b1;
      if (pop) fifo_q[0] <= fifo_q[1];
      if (enq) begin
        if (fill_q == {1'b0, pop}) fifo_q[0] <= new_e;
        else fifo_q[1] <= new_e;
      end
      unique case (state_q)
        IDLE: begin
`ifdef SDR_RESP_REFRESH_EN
          if (rpend_q) begin
            state_q <= REFRESH;
            cnt_q   <= CW'(1);
            rpend_q <= 1'b0;
          end else
`endif
          if ((fill_q != 2'd0) || enq) begin
            state_q <= WAIT;
            cnt_q   <= CW'(1);
          end
        end
        WAIT: begin
          if (pop) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef SDR_RESP_REFRESH_EN
        REFRESH: begin
          if (cnt_q == CW'(REFRESH_CYCLES)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
`ifdef SDR_RESP_REFRESH_EN
      // A wrap on the same edge as entering refresh re-arms the next one.
      if (rctr_q == RW'(REFRESH_PERIOD - 1)) begin
        rctr_q  <= '0;
        rpend_q <= 1'b1;
      end else begin
        rctr_q <= rctr_q + RW'(1);
      end
`endif
    end
  end

  always_ff @(posedge CLK_96M) begin
    if (reset) begin
      sdr_dout <= '0;
    end else if (commit) begin
      if (h_sel[1]) mem_q[h_addr][15:8] <= h_din[15:8];
      if (h_sel[0]) mem_q[h_addr][7:0] <= h_din[7:0];
      sdr_dout <= {h_sel[1] ? h_din[15:8] : mem_q[h_addr][15:8],
                   h_sel[0] ? h_din[7:0]  : mem_q[h_addr][7:0]};
    end
  end

endmodule
